// File: rtl/tt_mux_seq_if.sv
// tt_mux_seq_if: spine <-> user-module bundle for one row of the sequenced row mux.
// Ports: master drives addr/sel_in/ena_in/sel_stb/si_usr/um_ow and observes spine_ow/um_iw/um_ena/busy;
//        slave (tt_mux_seq) is the mirror image. Widths derive from the module shape parameters.
interface tt_mux_seq_if #(
  parameter int N_UM = 16,
  parameter int N_IO = 8,
  parameter int N_O  = 8,
  parameter int N_I  = 10
);
  localparam int U_OW = N_O + 2 * N_IO;
  localparam int U_IW = N_I + N_IO;

  logic [4:0]           addr;
  logic [9:0]           sel_in;
  logic                 ena_in;
  logic                 sel_stb;
  logic [U_IW-1:0]      si_usr;
  logic [U_OW+1:0]      spine_ow;
  logic [U_OW*N_UM-1:0] um_ow;
  logic [U_IW*N_UM-1:0] um_iw;
  logic [N_UM-1:0]      um_ena;
  logic                 busy;

  modport master (
    output addr, sel_in, ena_in, sel_stb, si_usr, um_ow,
    input  spine_ow, um_iw, um_ena, busy
  );

  modport slave (
    input  addr, sel_in, ena_in, sel_stb, si_usr, um_ow,
    output spine_ow, um_iw, um_ena, busy
  );
endinterface

// File: rtl/tt_mux_seq.sv
// tt_mux_seq: clocked row mux; latches spine select on sel_stb, switches modules break-before-make.
// Latency: new enable GUARD_CYC+1 cycles after the strobe; spine_ow +1 cycle when OUT_REG=1, else comb.
// Backpressure: none; a strobe is always accepted and restarts the break (last strobe wins).
// Ports: clk, rst_n (async active-low) plain; everything else through tt_mux_seq_if.slave.
module tt_mux_seq #(
  parameter int N_UM      = 16,
  parameter int N_IO      = 8,
  parameter int N_O       = 8,
  parameter int N_I       = 10,
  parameter int GUARD_CYC = 2,
  parameter int OUT_REG   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tt_mux_seq_if.slave bus
);
  localparam int U_OW = N_O + 2 * N_IO;
  localparam int U_IW = N_I + N_IO;
  localparam int CW   = $clog2(GUARD_CYC + 1);

  typedef enum logic [1:0] {IDLE, BREAK, ACTIVE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [4:0]      cur_idx, cur_idx_nx;
  logic [9:0]      pend_sel;
  logic            pend_ena;
  logic [N_UM-1:0] ena_q, ena_nx;

  logic            hit;
  logic            valid;
  logic [4:0]      idx;

  // Decode always works on the latched select, never on the live spine.
  assign hit   = (pend_sel[9:6] == bus.addr[4:1]) && (pend_sel[4] == bus.addr[0]);
  assign idx   = {pend_sel[3:0], pend_sel[5]};
  assign valid = hit && pend_ena && ({1'b0, idx} < 6'(N_UM));

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cur_idx_nx = cur_idx;
    ena_nx     = '0;
    if (bus.sel_stb) begin
      state_nx = BREAK;
      cnt_nx   = CW'(GUARD_CYC);
    end else if (state == BREAK) begin
      cnt_nx = cnt - CW'(1);
      if (cnt == CW'(1)) begin
        cur_idx_nx = idx;
        state_nx   = valid ? ACTIVE : IDLE;
      end
    end
    // Enables are computed from the next state so um_ena is a plain register
    // output: it can never show two hot bits, even transiently.
    if (state_nx == ACTIVE) begin
      for (int k = 0; k < N_UM; k++) begin
        ena_nx[k] = (cur_idx_nx == 5'(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_idx  <= '0;
      pend_sel <= '0;
      pend_ena <= 1'b0;
      ena_q    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur_idx <= cur_idx_nx;
      ena_q   <= ena_nx;
      if (bus.sel_stb) begin
        pend_sel <= bus.sel_in;
        pend_ena <= bus.ena_in;
      end
    end
  end

  assign bus.um_ena = ena_q;
  assign bus.busy   = (state == BREAK);

  // ena_q is non-zero exactly in ACTIVE with bit cur_idx set, so steering by
  // the enable vector is the same as indexing by cur_idx, without ever forming
  // an out-of-range part-select when cur_idx >= N_UM.
  logic [U_IW*N_UM-1:0] iw_fan;
  logic [U_OW-1:0]      so_comb;

  always_comb begin
    iw_fan  = '0;
    so_comb = '0;
    for (int k = 0; k < N_UM; k++) begin
      if (ena_q[k]) begin
        iw_fan[k*U_IW +: U_IW] = bus.si_usr;
        so_comb                = so_comb | bus.um_ow[k*U_OW +: U_OW];
      end
    end
  end

  assign bus.um_iw = iw_fan;

  logic [U_OW-1:0] so_usr;

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) so_usr <= '0;
        else        so_usr <= so_comb;
      end
    end else begin : g_ocomb
      assign so_usr = so_comb;
    end
  endgenerate

  // Guard bits on either side of the user field are tied low.
  assign bus.spine_ow = {1'b0, so_usr, 1'b0};
endmodule
